pl_ifid_haz: RTL and testbench

PL_IFID_HAZ -- requirements
Module: pl_ifid_haz

---
 rtl/pl_ifid_haz_if.sv | 53 +++++
 rtl/pl_ifid_haz.sv | 213 +++++++++++++++++++++
 tb/tb_pl_ifid_haz.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pl_ifid_haz_if.sv
// Fetch/decode bus of pl_ifid_haz: fetched instruction in,
// decoded IF/ID register and hazard hold out.
interface pl_ifid_haz_if #(
  parameter int DATA_WID     = 8,
  parameter int PROG_CTR_WID = 10
);
  logic [15:0]             instr_mem_out;
  logic                    instr_valid;
  logic [PROG_CTR_WID-1:0] fetch_pc;
  logic                    branch_taken_reg;
  logic                    stall_ex;
  logic [DATA_WID-1:0]     op1_data;
  logic [DATA_WID-1:0]     op2_data;

  logic [2:0]              op1_addr_IFID;
  logic [2:0]              op2_addr_IFID;
  logic                    pc_hold;
  logic                    IFID_valid;
  logic [20:0]             IFID_ctrl;
  logic [DATA_WID-1:0]     IFID_op1_data;
  logic [DATA_WID-1:0]     IFID_op2_data;
  logic [2:0]              IFID_op1_addr;
  logic [2:0]              IFID_op2_addr;
  logic [2:0]              IFID_res_addr;
  logic [7:0]              IFID_ld_addr;
  logic [7:0]              IFID_st_addr;
  logic [PROG_CTR_WID-1:0] IFID_br_target;
  logic [PROG_CTR_WID-1:0] IFID_pc;

  modport master (
    output instr_mem_out, instr_valid, fetch_pc,
    output branch_taken_reg, stall_ex,
    output op1_data, op2_data,
    input  op1_addr_IFID, op2_addr_IFID, pc_hold,
    input  IFID_valid, IFID_ctrl,
    input  IFID_op1_data, IFID_op2_data,
    input  IFID_op1_addr, IFID_op2_addr, IFID_res_addr,
    input  IFID_ld_addr, IFID_st_addr,
    input  IFID_br_target, IFID_pc
  );

  modport slave (
    input  instr_mem_out, instr_valid, fetch_pc,
    input  branch_taken_reg, stall_ex,
    input  op1_data, op2_data,
    output op1_addr_IFID, op2_addr_IFID, pc_hold,
    output IFID_valid, IFID_ctrl,
    output IFID_op1_data, IFID_op2_data,
    output IFID_op1_addr, IFID_op2_addr, IFID_res_addr,
    output IFID_ld_addr, IFID_st_addr,
    output IFID_br_target, IFID_pc
  );
endinterface

// File: rtl/pl_ifid_haz.sv
// Fetch (F) and decode (D) pipeline registers with branch flush,
// downstream stall and one-bubble load-use interlock.
module pl_ifid_haz #(
  parameter int DATA_WID     = 8,
  parameter int PROG_CTR_WID = 10
) (
  input  logic          clk,
  input  logic          rst,
  pl_ifid_haz_if.slave  bus
);
  if (PROG_CTR_WID < 10) begin : g_pcw_chk
    $error("PROG_CTR_WID must be at least 10");
  end

  localparam int C_ADD   = 0;
  localparam int C_AND   = 1;
  localparam int C_OR    = 2;
  localparam int C_NOT   = 3;
  localparam int C_ANDB  = 4;
  localparam int C_ORB   = 5;
  localparam int C_NOTB  = 6;
  localparam int C_CIN   = 7;
  localparam int C_OP2C  = 8;
  localparam int C_JMP   = 9;
  localparam int C_CMP   = 10;
  localparam int C_SHL   = 11;
  localparam int C_LGCL  = 12;
  localparam int C_LD    = 13;
  localparam int C_ST    = 14;
  localparam int C_WR    = 15;
  localparam int C_UNC   = 16;
  localparam int C_JGT   = 17;
  localparam int C_JLT   = 18;
  localparam int C_JEQ   = 19;
  localparam int C_JC    = 20;

  function automatic logic [20:0] decode(input logic [4:0] op);
    logic [20:0] c;
    c = '0;
    unique case (1'b1)
      (op == 5'h01): begin
        c[C_ADD] = 1'b1;
        c[C_WR]  = 1'b1;
      end
      (op == 5'h02): begin
        c[C_ADD]  = 1'b1;
        c[C_CIN]  = 1'b1;
        c[C_OP2C] = 1'b1;
        c[C_WR]   = 1'b1;
      end
      (op == 5'h03): begin
        c[C_AND]  = 1'b1;
        c[C_LGCL] = 1'b1;
        c[C_WR]   = 1'b1;
      end
      (op == 5'h04): begin
        c[C_OR]   = 1'b1;
        c[C_LGCL] = 1'b1;
        c[C_WR]   = 1'b1;
      end
      (op == 5'h05): begin
        c[C_NOT]  = 1'b1;
        c[C_LGCL] = 1'b1;
        c[C_WR]   = 1'b1;
      end
      (op == 5'h06): begin
        c[C_SHL] = 1'b1;
        c[C_WR]  = 1'b1;
      end
      (op == 5'h07): begin
        c[C_JMP] = 1'b1;
        c[C_UNC] = 1'b1;
      end
      (op == 5'h08): begin
        c[C_LD] = 1'b1;
        c[C_WR] = 1'b1;
      end
      (op == 5'h09): c[C_ST] = 1'b1;
      (op == 5'h0A): begin
        c[C_ANDB] = 1'b1;
        c[C_LGCL] = 1'b1;
        c[C_WR]   = 1'b1;
      end
      (op == 5'h0B): begin
        c[C_ORB]  = 1'b1;
        c[C_LGCL] = 1'b1;
        c[C_WR]   = 1'b1;
      end
      (op == 5'h0C): begin
        c[C_NOTB] = 1'b1;
        c[C_LGCL] = 1'b1;
        c[C_WR]   = 1'b1;
      end
      (op == 5'h0D): begin
        c[C_ADD]  = 1'b1;
        c[C_CMP]  = 1'b1;
        c[C_CIN]  = 1'b1;
        c[C_OP2C] = 1'b1;
      end
      (op == 5'h0E): begin
        c[C_JMP] = 1'b1;
        c[C_JGT] = 1'b1;
      end
      (op == 5'h0F): begin
        c[C_JMP] = 1'b1;
        c[C_JLT] = 1'b1;
      end
      (op == 5'h10): begin
        c[C_JMP] = 1'b1;
        c[C_JEQ] = 1'b1;
      end
      (op == 5'h11): begin
        c[C_JMP] = 1'b1;
        c[C_JC]  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  logic [15:0]             f_instr;
  logic [PROG_CTR_WID-1:0] f_pc;
  logic                    f_valid;

  logic                    d_valid;
  logic [20:0]             d_ctrl;
  logic [DATA_WID-1:0]     d_op1_data;
  logic [DATA_WID-1:0]     d_op2_data;
  logic [2:0]              d_op1_addr;
  logic [2:0]              d_op2_addr;
  logic [2:0]              d_res_addr;
  logic [7:0]              d_ld_addr;
  logic [7:0]              d_st_addr;
  logic [PROG_CTR_WID-1:0] d_br_target;
  logic [PROG_CTR_WID-1:0] d_pc;

  logic [4:0] f_op;
  logic [2:0] f_op1;
  logic [2:0] f_op2;
  logic       f_reads;
  logic       load_use;

  assign f_op  = f_instr[15:11];
  assign f_op1 = f_instr[2:0];
  assign f_op2 = f_instr[6:4];

  // only ALU/logic ops and store read the register file
  assign f_reads = (f_op >= 5'h01 && f_op <= 5'h06)
                 | (f_op >= 5'h09 && f_op <= 5'h0D);

  assign load_use = d_valid & d_ctrl[C_LD] & f_valid & f_reads
                  & ((d_res_addr == f_op1) | (d_res_addr == f_op2));

  always_ff @(posedge clk) begin
    if (rst) begin
      f_instr     <= '0;
      f_pc        <= '0;
      f_valid     <= 1'b0;
      d_valid     <= 1'b0;
      d_ctrl      <= '0;
      d_op1_data  <= '0;
      d_op2_data  <= '0;
      d_op1_addr  <= '0;
      d_op2_addr  <= '0;
      d_res_addr  <= '0;
      d_ld_addr   <= '0;
      d_st_addr   <= '0;
      d_br_target <= '0;
      d_pc        <= '0;
    end else if (bus.branch_taken_reg) begin
      f_valid <= 1'b0;
      d_valid <= 1'b0;
      d_ctrl  <= '0;
    end else if (bus.stall_ex) begin
      f_valid <= f_valid;
    end else if (load_use) begin
      d_valid <= 1'b0;
      d_ctrl  <= '0;
    end else begin
      f_instr     <= bus.instr_mem_out;
      f_pc        <= bus.fetch_pc;
      f_valid     <= bus.instr_valid;
      d_valid     <= f_valid;
      d_ctrl      <= f_valid ? decode(f_op) : '0;
      d_op1_data  <= bus.op1_data;
      d_op2_data  <= bus.op2_data;
      d_op1_addr  <= f_op1;
      d_op2_addr  <= f_op2;
      d_res_addr  <= f_instr[10:8];
      d_ld_addr   <= f_instr[7:0];
      d_st_addr   <= f_instr[10:3];
      d_br_target <= PROG_CTR_WID'(f_instr[9:0]);
      d_pc        <= f_pc;
    end
  end

  assign bus.pc_hold = ~rst & ~bus.branch_taken_reg
                     & (bus.stall_ex | load_use);

  assign bus.op1_addr_IFID  = f_op1;
  assign bus.op2_addr_IFID  = f_op2;
  assign bus.IFID_valid     = d_valid;
  assign bus.IFID_ctrl      = d_ctrl;
  assign bus.IFID_op1_data  = d_op1_data;
  assign bus.IFID_op2_data  = d_op2_data;
  assign bus.IFID_op1_addr  = d_op1_addr;
  assign bus.IFID_op2_addr  = d_op2_addr;
  assign bus.IFID_res_addr  = d_res_addr;
  assign bus.IFID_ld_addr   = d_ld_addr;
  assign bus.IFID_st_addr   = d_st_addr;
  assign bus.IFID_br_target = d_br_target;
  assign bus.IFID_pc        = d_pc;
endmodule

// File: tb/tb_pl_ifid_haz.sv
// Directed bench for pl_ifid_haz: decode table, load-use,
// branch flush, stall hold and reset behaviour.
module tb_pl_ifid_haz;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pl_ifid_haz_if #(.DATA_WID(8), .PROG_CTR_WID(10)) bus ();

  pl_ifid_haz #(.DATA_WID(8), .PROG_CTR_WID(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] ins,
                       input logic v,
                       input logic [9:0] pc);
    bus.instr_mem_out = ins;
    bus.instr_valid   = v;
    bus.fetch_pc      = pc;
  endtask

  logic [4:0]  ops [20];
  logic [20:0] ctl [20];

  initial begin
    ops = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05,
            5'h06, 5'h07, 5'h08, 5'h09, 5'h0A,
            5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F,
            5'h10, 5'h11, 5'h00, 5'h12, 5'h1F};
    ctl = '{21'h08001, 21'h08181, 21'h09002, 21'h09004,
            21'h09008, 21'h08800, 21'h10200, 21'h0A000,
            21'h04000, 21'h09010, 21'h09020, 21'h09040,
            21'h00581, 21'h20200, 21'h40200, 21'h80200,
            21'h100200, 21'h0, 21'h0, 21'h0};

    rst = 1'b1;
    drive(16'h0, 1'b0, 10'h0);
    bus.branch_taken_reg = 1'b0;
    bus.stall_ex         = 1'b1;
    bus.op1_data         = 8'h0;
    bus.op2_data         = 8'h0;
    tick();
    tick();
    chk("rst_valid", 32'(bus.IFID_valid), 32'd0);
    chk("rst_ctrl", 32'(bus.IFID_ctrl), 32'd0);
    chk("rst_hold", 32'(bus.pc_hold), 32'd0);
    rst          = 1'b0;
    bus.stall_ex = 1'b0;

    // plain ADD, two-edge latency
    drive(16'h0A21, 1'b1, 10'h010);
    tick();
    drive(16'h0, 1'b0, 10'h011);
    bus.op1_data = 8'h05;
    bus.op2_data = 8'h07;
    chk("add_f_op1", 32'(bus.op1_addr_IFID), 32'd1);
    chk("add_f_op2", 32'(bus.op2_addr_IFID), 32'd2);
    chk("add_early", 32'(bus.IFID_valid), 32'd0);
    tick();
    chk("add_valid", 32'(bus.IFID_valid), 32'd1);
    chk("add_ctrl", 32'(bus.IFID_ctrl), 32'h08001);
    chk("add_res", 32'(bus.IFID_res_addr), 32'd2);
    chk("add_d1", 32'(bus.IFID_op1_data), 32'h05);
    chk("add_d2", 32'(bus.IFID_op2_data), 32'h07);
    chk("add_pc", 32'(bus.IFID_pc), 32'h010);

    // LOAD r3 then dependent ADD
    drive(16'h4310, 1'b1, 10'h020);
    tick();
    drive(16'h0B31, 1'b1, 10'h021);
    tick();
    chk("ld_valid", 32'(bus.IFID_valid), 32'd1);
    chk("ld_ctrl", 32'(bus.IFID_ctrl), 32'h0A000);
    chk("ld_res", 32'(bus.IFID_res_addr), 32'd3);
    chk("ld_addr", 32'(bus.IFID_ld_addr), 32'h10);
    drive(16'h0, 1'b0, 10'h022);
    bus.op1_data = 8'h11;
    bus.op2_data = 8'h22;
    #1;
    chk("lu_hold", 32'(bus.pc_hold), 32'd1);
    tick();
    chk("lu_bub_v", 32'(bus.IFID_valid), 32'd0);
    chk("lu_bub_c", 32'(bus.IFID_ctrl), 32'd0);
    chk("lu_hold2", 32'(bus.pc_hold), 32'd0);
    bus.op1_data = 8'h33;
    bus.op2_data = 8'h44;
    tick();
    chk("lu_add_v", 32'(bus.IFID_valid), 32'd1);
    chk("lu_add_c", 32'(bus.IFID_ctrl), 32'h08001);
    chk("lu_add_o2", 32'(bus.IFID_op2_addr), 32'd3);
    chk("lu_add_d1", 32'(bus.IFID_op1_data), 32'h33);
    chk("lu_add_pc", 32'(bus.IFID_pc), 32'h021);

    // jump after load does not interlock
    drive(16'h4310, 1'b1, 10'h028);
    tick();
    drive(16'h3803, 1'b1, 10'h029);
    tick();
    drive(16'h0, 1'b0, 10'h02A);
    #1;
    chk("ld_jmp_hold", 32'(bus.pc_hold), 32'd0);
    tick();
    chk("ld_jmp_v", 32'(bus.IFID_valid), 32'd1);
    chk("ld_jmp_c", 32'(bus.IFID_ctrl), 32'h10200);

    // JMP then taken branch flushes both slots
    drive(16'h3955, 1'b1, 10'h030);
    tick();
    drive(16'h0A21, 1'b1, 10'h031);
    tick();
    chk("jmp_ctrl", 32'(bus.IFID_ctrl), 32'h10200);
    chk("jmp_tgt", 32'(bus.IFID_br_target), 32'h155);
    chk("jmp_valid", 32'(bus.IFID_valid), 32'd1);
    drive(16'h0A21, 1'b1, 10'h032);
    bus.branch_taken_reg = 1'b1;
    #1;
    chk("br_hold", 32'(bus.pc_hold), 32'd0);
    tick();
    bus.branch_taken_reg = 1'b0;
    drive(16'h0, 1'b0, 10'h033);
    chk("br_slot1", 32'(bus.IFID_valid), 32'd0);
    tick();
    chk("br_slot2", 32'(bus.IFID_valid), 32'd0);

    // SUB held under a three-cycle stall
    drive(16'h1132, 1'b1, 10'h040);
    tick();
    drive(16'h0, 1'b0, 10'h041);
    bus.op1_data = 8'h0F;
    bus.op2_data = 8'h0E;
    tick();
    chk("sub_ctrl", 32'(bus.IFID_ctrl), 32'h08181);
    chk("sub_d1", 32'(bus.IFID_op1_data), 32'h0F);
    drive(16'h0A21, 1'b1, 10'h042);
    bus.op1_data = 8'hAA;
    bus.op2_data = 8'hBB;
    bus.stall_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stl_hold", 32'(bus.pc_hold), 32'd1);
      tick();
      chk("stl_valid", 32'(bus.IFID_valid), 32'd1);
      chk("stl_ctrl", 32'(bus.IFID_ctrl), 32'h08181);
      chk("stl_d1", 32'(bus.IFID_op1_data), 32'h0F);
      chk("stl_pc", 32'(bus.IFID_pc), 32'h040);
    end
    bus.branch_taken_reg = 1'b1;
    #1;
    chk("stl_br_hold", 32'(bus.pc_hold), 32'd0);
    tick();
    chk("stl_br_v", 32'(bus.IFID_valid), 32'd0);
    bus.branch_taken_reg = 1'b0;
    bus.stall_ex         = 1'b0;
    drive(16'h0, 1'b0, 10'h0);
    tick();

    // reset during the load-use bubble
    drive(16'h4310, 1'b1, 10'h060);
    tick();
    drive(16'h0B31, 1'b1, 10'h061);
    tick();
    drive(16'h0, 1'b0, 10'h062);
    #1;
    chk("lu2_hold", 32'(bus.pc_hold), 32'd1);
    tick();
    chk("lu2_bub", 32'(bus.IFID_valid), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_hold2", 32'(bus.pc_hold), 32'd0);
    tick();
    chk("rst2_valid", 32'(bus.IFID_valid), 32'd0);
    chk("rst2_res", 32'(bus.IFID_res_addr), 32'd0);
    chk("rst2_pc", 32'(bus.IFID_pc), 32'd0);
    chk("rst2_d1", 32'(bus.IFID_op1_data), 32'd0);
    chk("rst2_ld", 32'(bus.IFID_ld_addr), 32'd0);
    chk("rst2_fop2", 32'(bus.op2_addr_IFID), 32'd0);
    rst = 1'b0;

    // undefined opcode 0x1F decodes as NOP
    drive(16'hFF21, 1'b1, 10'h050);
    tick();
    chk("nop_f_op1", 32'(bus.op1_addr_IFID), 32'd1);
    drive(16'h0, 1'b0, 10'h051);
    tick();
    chk("nop_valid", 32'(bus.IFID_valid), 32'd1);
    chk("nop_ctrl", 32'(bus.IFID_ctrl), 32'd0);
    tick();
    chk("nop_inv", 32'(bus.IFID_valid), 32'd0);

    // full opcode table
    for (int i = 0; i < 20; i++) begin
      drive({ops[i], 11'h4D3}, 1'b1, 10'h100);
      tick();
      drive(16'h0, 1'b0, 10'h101);
      tick();
      chk($sformatf("dec_%0h", ops[i]),
          32'(bus.IFID_ctrl), 32'(ctl[i]));
    end
    chk("st_addr", 32'(bus.IFID_st_addr), 32'h9A);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
